// File: rtl/four_bit_counter_with_load.sv
// Up/down/load counter driven by raw push-buttons.
// Each button is synchronized and debounced, then edge-detected into a single press.
module four_bit_counter_with_load_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_run;
    logic                   r_level;
    logic                   w_in;
    logic                   w_full;

    assign w_in   = r_sync[SYNC_STAGES-1];
    assign w_full = (r_run == LAST);

    // Press fires on the same edge the debounced level rises.
    assign o_press = !i_rst && w_in && !r_level && w_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_run   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync[0] <= i_btn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            if (w_in == r_level) begin
                r_run <= '0;
            end else if (w_full) begin
                r_level <= w_in;
                r_run   <= '0;
            end else begin
                r_run <= r_run + 1'b1;
            end
        end
    end
endmodule

module four_bit_counter_with_load #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       resetButton,
    input  logic       upButton,
    input  logic       downButton,
    input  logic       loadButton,
    input  logic [3:0] switches,
    output logic [3:0] counter,
    output logic       ack
);
    logic       w_up;
    logic       w_down;
    logic       w_load;
    logic [3:0] r_counter;
    logic       r_ack;

    four_bit_counter_with_load_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
        .i_clk  (clock),
        .i_rst  (resetButton),
        .i_btn  (upButton),
        .o_press(w_up)
    );

    four_bit_counter_with_load_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down (
        .i_clk  (clock),
        .i_rst  (resetButton),
        .i_btn  (downButton),
        .o_press(w_down)
    );

    four_bit_counter_with_load_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load (
        .i_clk  (clock),
        .i_rst  (resetButton),
        .i_btn  (loadButton),
        .o_press(w_load)
    );

    // Load wins outright; up and down together cancel but still acknowledge.
    always_ff @(posedge clock) begin
        if (resetButton) begin
            r_counter <= 4'd0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_up | w_down | w_load;
            if (w_load) begin
                r_counter <= switches;
            end else if (w_up && !w_down) begin
                r_counter <= r_counter + 4'd1;
            end else if (w_down && !w_up) begin
                r_counter <= r_counter - 4'd1;
            end
        end
    end

    assign counter = r_counter;
    assign ack     = r_ack;
endmodule

// File: tb/tb_four_bit_counter_with_load.sv
// Directed bench for four_bit_counter_with_load.
// Expected (cycle, value) pairs are queued at each press and retired on ack.
module tb_four_bit_counter_with_load;
    logic       clock = 1'b0;
    logic       resetButton;
    logic       upButton;
    logic       downButton;
    logic       loadButton;
    logic [3:0] switches;
    logic [3:0] counter;
    logic       ack;

    typedef struct {
        int         due;
        logic [3:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] model = 4'd0;

    localparam int LAT = 6;

    four_bit_counter_with_load dut (
        .clock      (clock),
        .resetButton(resetButton),
        .upButton   (upButton),
        .downButton (downButton),
        .loadButton (loadButton),
        .switches   (switches),
        .counter    (counter),
        .ack        (ack)
    );

    always #5 clock = ~clock;

    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        if (q.size() > 0 && cyc >= q[0].due) begin
            e = q.pop_front();
            checks++;
            assert (ack === 1'b1 && cyc == e.due) else begin
                errors++;
                $error("FAIL ack_due cyc=%0d due=%0d ack=%b want 1", cyc, e.due, ack);
            end
            checks++;
            assert (counter === e.cnt) else begin
                errors++;
                $error("FAIL count cyc=%0d got=%0d want=%0d", cyc, counter, e.cnt);
            end
        end else begin
            checks++;
            assert (ack === 1'b0) else begin
                errors++;
                $error("FAIL ack_idle cyc=%0d got=%b want 0", cyc, ack);
            end
        end
    endtask

    task automatic expect_press(input logic [3:0] v);
        exp_t e;
        e.due = cyc + LAT;
        e.cnt = v;
        q.push_back(e);
        model = v;
    endtask

    task automatic hold(input logic u, input logic d, input logic l,
                        input int n, input int gap);
        upButton   = u;
        downButton = d;
        loadButton = l;
        repeat (n) tick();
        upButton   = 1'b0;
        downButton = 1'b0;
        loadButton = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic check_count(input string tag);
        checks++;
        assert (counter === model) else begin
            errors++;
            $error("FAIL %s got=%0d want=%0d", tag, counter, model);
        end
    endtask

    initial begin
        resetButton = 1'b1;
        upButton    = 1'b0;
        downButton  = 1'b0;
        loadButton  = 1'b0;
        switches    = 4'd0;
        repeat (5) begin
            tick();
            check_count("reset_hold");
        end
        resetButton = 1'b0;
        tick();
        check_count("reset_after");

        // three up presses
        for (int i = 1; i <= 3; i++) begin
            expect_press(4'(i));
            hold(1'b1, 1'b0, 1'b0, 5, 4);
        end
        repeat (4) tick();
        check_count("up_x3");

        // load 5 then six downs wrapping to 15
        switches = 4'd5;
        expect_press(4'd5);
        hold(1'b0, 1'b0, 1'b1, 5, 6);
        check_count("load5");
        for (int i = 0; i < 6; i++) begin
            expect_press(model - 4'd1);
            hold(1'b0, 1'b1, 1'b0, 5, 6);
        end
        check_count("down_wrap");

        // 15 -> 0, then a short glitch
        expect_press(4'd0);
        hold(1'b1, 1'b0, 1'b0, 5, 8);
        check_count("up_wrap");
        hold(1'b1, 1'b0, 1'b0, 2, 10);
        check_count("glitch");

        // long hold yields a single press
        expect_press(4'd1);
        hold(1'b1, 1'b0, 1'b0, 20, 8);
        check_count("long_hold");

        // load beats up; up+down cancels but acks
        switches = 4'd9;
        expect_press(4'd9);
        hold(1'b1, 1'b0, 1'b1, 5, 8);
        check_count("load_prio");
        expect_press(4'd9);
        hold(1'b1, 1'b1, 1'b0, 5, 8);
        check_count("up_down");

        // reset in the middle of a press
        upButton = 1'b1;
        repeat (3) tick();
        resetButton = 1'b1;
        upButton    = 1'b0;
        model       = 4'd0;
        repeat (2) tick();
        resetButton = 1'b0;
        repeat (12) tick();
        check_count("reset_mid");

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL pending got=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
